// File: rtl/maze_pkg.sv
`default_nettype none
//==============================================================================
// Module   : maze_pkg
// Purpose  : Cell codes, colour constants and VGA 640x480 timing for the maze
//            display path.
// Revision : 1.0 - initial release
//==============================================================================
package maze_pkg;

    typedef enum logic {
        WALL = 1'b0,
        PATH = 1'b1
    } cell_t;

    // {R,G,B}, one bit per colour
    localparam logic [2:0] COL_BLACK  = 3'b000;
    localparam logic [2:0] COL_WALL   = 3'b001;
    localparam logic [2:0] COL_PATH   = 3'b111;
    localparam logic [2:0] COL_START  = 3'b010;
    localparam logic [2:0] COL_CURSOR = 3'b100;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
//==============================================================================
// Module   : vga_timing
// Purpose  : Free-running h/v raster counters with raw syncs and active flag.
// Revision : 1.0 - initial release
//==============================================================================
module vga_timing
    import maze_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       hsync_raw,
    output logic       vsync_raw,
    output logic       active
);

    localparam logic [9:0] C_H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] C_V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] C_HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] C_HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] C_VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] C_VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] C_H_ACTIVE   = 10'(H_ACTIVE);
    localparam logic [9:0] C_V_ACTIVE   = 10'(V_ACTIVE);

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == C_H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == C_V_LAST) ? '0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    assign h_cnt     = r_h_cnt;
    assign v_cnt     = r_v_cnt;
    assign hsync_raw = !((r_h_cnt >= C_HS_START) && (r_h_cnt < C_HS_END));
    assign vsync_raw = !((r_v_cnt >= C_VS_START) && (r_v_cnt < C_VS_END));
    assign active    = (r_h_cnt < C_H_ACTIVE) && (r_v_cnt < C_V_ACTIVE);

endmodule
`default_nettype wire

// File: rtl/maze_vga_renderer.sv
`default_nettype none
//==============================================================================
// Module   : maze_vga_renderer
// Purpose  : Renders a per-frame snapshot of the maze bitmap as centred tiles
//            with a cursor overlay on a VGA raster (2-clock pipeline).
// Revision : 1.0 - initial release
//==============================================================================
module maze_vga_renderer
    import maze_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter int MAZE_W     = 16,
    parameter int MAZE_H     = 16,
    parameter int CELL_SHIFT = 4,
    parameter int X_OFFSET   = 192,
    parameter int Y_OFFSET   = 112
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [MAZE_W*MAZE_H-1:0]   maze_data,
    input  logic                       maze_valid,
    input  logic [4:0]                 cursor_x,
    input  logic [4:0]                 cursor_y,
    output logic                       hsync,
    output logic                       vsync,
    output logic [2:0]                 rgb,
    output logic                       frame_start
);

    // MAZE_W and MAZE_H are powers of two, so the bit index is simply {cy, cx}
    localparam int CX_W  = $clog2(MAZE_W);
    localparam int CY_W  = $clog2(MAZE_H);
    localparam int IDX_W = CX_W + CY_W;

    localparam logic [9:0] C_H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] C_V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] C_X_LO   = 10'(X_OFFSET);
    localparam logic [9:0] C_X_HI   = 10'(X_OFFSET + (MAZE_W << CELL_SHIFT));
    localparam logic [9:0] C_Y_LO   = 10'(Y_OFFSET);
    localparam logic [9:0] C_Y_HI   = 10'(Y_OFFSET + (MAZE_H << CELL_SHIFT));

    logic [9:0] w_h_cnt;
    logic [9:0] w_v_cnt;
    logic       w_hsync_raw;
    logic       w_vsync_raw;
    logic       w_active;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk       (clk),
        .reset     (reset),
        .h_cnt     (w_h_cnt),
        .v_cnt     (w_v_cnt),
        .hsync_raw (w_hsync_raw),
        .vsync_raw (w_vsync_raw),
        .active    (w_active)
    );

    // Frame snapshot: only the last pixel of a frame may refresh it
    logic [MAZE_W*MAZE_H-1:0] r_snapshot;
    logic [4:0]               r_cur_x;
    logic [4:0]               r_cur_y;
    logic                     w_frame_end;

    assign w_frame_end = (w_h_cnt == C_H_LAST) && (w_v_cnt == C_V_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_snapshot <= '0;
            r_cur_x    <= 5'd31;
            r_cur_y    <= 5'd31;
        end else if (w_frame_end && maze_valid) begin
            r_snapshot <= maze_data;
            r_cur_x    <= cursor_x;
            r_cur_y    <= cursor_y;
        end
    end

    // Stage 1: tile lookup
    logic [9:0]      w_h_rel;
    logic [9:0]      w_v_rel;
    logic [CX_W-1:0] w_cx;
    logic [CY_W-1:0] w_cy;
    logic [IDX_W-1:0] w_idx;
    logic            w_in_maze;

    assign w_h_rel   = w_h_cnt - C_X_LO;
    assign w_v_rel   = w_v_cnt - C_Y_LO;
    assign w_cx      = CX_W'(w_h_rel >> CELL_SHIFT);
    assign w_cy      = CY_W'(w_v_rel >> CELL_SHIFT);
    assign w_idx     = {w_cy, w_cx};
    assign w_in_maze = w_active
                     && (w_h_cnt >= C_X_LO) && (w_h_cnt < C_X_HI)
                     && (w_v_cnt >= C_Y_LO) && (w_v_cnt < C_Y_HI);

    logic  r_s1_valid;
    cell_t r_s1_cell;
    logic  r_s1_cursor;
    logic  r_s1_start;
    logic  r_s1_in_maze;
    logic  r_s1_active;
    logic  r_s1_hsync;
    logic  r_s1_vsync;
    logic  r_s1_first;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid   <= 1'b0;
            r_s1_cell    <= WALL;
            r_s1_cursor  <= 1'b0;
            r_s1_start   <= 1'b0;
            r_s1_in_maze <= 1'b0;
            r_s1_active  <= 1'b0;
            r_s1_hsync   <= 1'b1;
            r_s1_vsync   <= 1'b1;
            r_s1_first   <= 1'b0;
        end else begin
            r_s1_valid   <= 1'b1;
            r_s1_cell    <= cell_t'(r_snapshot[w_idx]);
            // 5-bit compare so an off-grid cursor (>15) can never match
            r_s1_cursor  <= (r_cur_x == 5'(w_cx)) && (r_cur_y == 5'(w_cy));
            r_s1_start   <= (w_cx == '0) && (w_cy == '0);
            r_s1_in_maze <= w_in_maze;
            r_s1_active  <= w_active;
            r_s1_hsync   <= w_hsync_raw;
            r_s1_vsync   <= w_vsync_raw;
            r_s1_first   <= (w_h_cnt == 10'd0) && (w_v_cnt == 10'd0);
        end
    end

    // Stage 2: colour priority and pin registers
    logic [2:0] w_rgb_next;

    always_comb begin
        w_rgb_next = COL_BLACK;
        if (r_s1_valid && r_s1_active && r_s1_in_maze) begin
            if (r_s1_cursor)
                w_rgb_next = COL_CURSOR;
            else if (r_s1_start)
                w_rgb_next = COL_START;
            else if (r_s1_cell == PATH)
                w_rgb_next = COL_PATH;
            else
                w_rgb_next = COL_WALL;
        end
    end

    logic       r_hsync;
    logic       r_vsync;
    logic [2:0] r_rgb;
    logic       r_frame_start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_rgb         <= COL_BLACK;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= r_s1_valid ? r_s1_hsync : 1'b1;
            r_vsync       <= r_s1_valid ? r_s1_vsync : 1'b1;
            r_rgb         <= w_rgb_next;
            r_frame_start <= r_s1_valid && r_s1_first;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign rgb         = r_rgb;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_maze_vga_renderer.sv
`default_nettype none
//==============================================================================
// Module   : tb_maze_vga_renderer
// Purpose  : Directed bench for maze_vga_renderer on a scaled raster
//            (64x48 total, 2-px tiles, maze at (8,4)) to keep runs short.
// Revision : 1.0 - initial release
//==============================================================================
module tb_maze_vga_renderer;

    localparam int HT    = 64;
    localparam int VT    = 48;
    localparam int FRAME = HT * VT;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [255:0] maze_data;
    logic         maze_valid;
    logic [4:0]   cursor_x;
    logic [4:0]   cursor_y;
    logic         hsync;
    logic         vsync;
    logic [2:0]   rgb;
    logic         frame_start;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;

    int   fs_cnt, fs_first, fs_second;
    int   hs_f1, hs_f2, hs_r1, vs_f1, vs_f2, vs_r1;
    logic prev_hs, prev_vs;
    logic [2:0] rgb_f0;

    maze_vga_renderer #(
        .H_ACTIVE   (48), .H_FP (4), .H_SYNC (8), .H_BP (4),
        .V_ACTIVE   (40), .V_FP (2), .V_SYNC (2), .V_BP (4),
        .MAZE_W     (16), .MAZE_H (16),
        .CELL_SHIFT (1),
        .X_OFFSET   (8),  .Y_OFFSET (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .maze_data   (maze_data),
        .maze_valid  (maze_valid),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .frame_start (frame_start)
    );

    always #20 clk = ~clk;

    // Clocks since reset release; pins show raster index cyc-2
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic goto_px(input int f, input int h, input int v);
        int target = f * FRAME + v * HT + h + 2;
        int guard  = 0;
        while (cyc < target && guard < 100000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc != target) chk("goto", cyc, target);
    endtask

    initial begin
        maze_data  = '1;
        maze_valid = 1'b1;
        cursor_x   = 5'd31;
        cursor_y   = 5'd31;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_rgb", rgb, 0);
        chk("rst_fs", frame_start, 0);

        fs_cnt = 0; fs_first = -1; fs_second = -1;
        hs_f1 = -1; hs_f2 = -1; hs_r1 = -1;
        vs_f1 = -1; vs_f2 = -1; vs_r1 = -1;
        prev_hs = 1'b1; prev_vs = 1'b1; rgb_f0 = 3'b000;

        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 2 * FRAME + 100; k++) begin
            @(posedge clk);
            #1;
            if (frame_start === 1'b1) begin
                if (fs_cnt == 0) fs_first = cyc;
                else if (fs_cnt == 1) fs_second = cyc;
                fs_cnt++;
            end
            if (prev_hs === 1'b1 && hsync === 1'b0) begin
                if (hs_f1 < 0) hs_f1 = cyc;
                else if (hs_f2 < 0) hs_f2 = cyc;
            end
            if (prev_hs === 1'b0 && hsync === 1'b1 && hs_f1 >= 0 && hs_r1 < 0) hs_r1 = cyc;
            if (prev_vs === 1'b1 && vsync === 1'b0) begin
                if (vs_f1 < 0) vs_f1 = cyc;
                else if (vs_f2 < 0) vs_f2 = cyc;
            end
            if (prev_vs === 1'b0 && vsync === 1'b1 && vs_f1 >= 0 && vs_r1 < 0) vs_r1 = cyc;
            if (cyc == 4 * HT + 10 + 2) rgb_f0 = rgb;
            prev_hs = hsync;
            prev_vs = vsync;
        end
        chk("fs_first", fs_first, 2);
        chk("fs_period", fs_second - fs_first, FRAME);
        chk("fs_count", fs_cnt, 3);
        chk("hs_first_fall", hs_f1, 54);
        chk("hs_period", hs_f2 - hs_f1, HT);
        chk("hs_low", hs_r1 - hs_f1, 8);
        chk("vs_first_fall", vs_f1, 2690);
        chk("vs_period", vs_f2 - vs_f1, FRAME);
        chk("vs_low", vs_r1 - vs_f1, 2 * HT);
        chk("f0_cleared_snap", rgb_f0, 3'b001);

        // Frame 2: all-path maze, off-grid cursor
        goto_px(2, 50, 2);  chk("blank_50_2", rgb, 3'b000);
        goto_px(2, 3, 3);   chk("outside_3_3", rgb, 3'b000);
        goto_px(2, 8, 4);   chk("start_8_4", rgb, 3'b010);
        goto_px(2, 9, 4);   chk("start_9_4", rgb, 3'b010);
        goto_px(2, 10, 4);  chk("path_10_4", rgb, 3'b111);
        goto_px(2, 51, 4);  chk("hs_51", hsync, 1);
        goto_px(2, 52, 4);  chk("hs_52", hsync, 0);

        maze_data = '0;
        cursor_x  = 5'd3;
        cursor_y  = 5'd2;
        goto_px(3, 13, 8);  chk("wall_13_8", rgb, 3'b001);
        goto_px(3, 14, 8);  chk("cur_14_8", rgb, 3'b100);
        goto_px(3, 15, 8);  chk("cur_15_8", rgb, 3'b100);
        goto_px(3, 16, 8);  chk("wall_16_8", rgb, 3'b001);
        goto_px(3, 14, 9);  chk("cur_14_9", rgb, 3'b100);
        goto_px(3, 15, 9);  chk("cur_15_9", rgb, 3'b100);

        // Mid-frame bitmap change appears only after the boundary
        goto_px(4, 0, 2);
        maze_data[17] = 1'b1;
        goto_px(4, 10, 6);  chk("bit17_same_frame", rgb, 3'b001);
        goto_px(5, 10, 6);  chk("bit17_next_frame", rgb, 3'b111);
        maze_valid = 1'b0;
        maze_data  = '0;
        cursor_x   = 5'd31;
        cursor_y   = 5'd31;
        goto_px(6, 10, 6);  chk("hold_bit17", rgb, 3'b111);
        goto_px(6, 14, 8);  chk("hold_cursor", rgb, 3'b100);

        // Asynchronous reset mid-frame
        goto_px(7, 30, 20); chk("pre_rst_rgb", rgb, 3'b001);
        reset = 1'b0;
        #1;
        chk("async_rst_rgb", rgb, 0);
        chk("async_rst_hs", hsync, 1);
        chk("async_rst_vs", vsync, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_rst_rgb", rgb, 0);
        chk("hold_rst_fs", frame_start, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rel_fs_c1", frame_start, 0);
        @(posedge clk); #1;
        chk("rel_fs_c2", frame_start, 1);
        goto_px(0, 10, 6);  chk("rel_snap_cleared", rgb, 3'b001);
        goto_px(0, 14, 8);  chk("rel_cursor_cleared", rgb, 3'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
